pipe_ctrl: RTL and testbench

- Feeder/consumer end of the hazard unit interface in the 5-stage MIPS pipeline.
- Tracks destination-register and memory-op metadata through the ID/EX, EX/MEM and MEM/WB latches, and drives the EX/MEM-side fields the hazard unit reads.
- Consumes the hazard unit's hazard/branch/jump results and ihit/dhit, and generates per-latch enable/flush and PC enable.
- Owns the data-memory wait and halt sequencing.

---
 rtl/cpu_types_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 64 ++++++
 rtl/pipe_meta_reg.sv | 26 ++
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register select, pipeline-control state and the
// per-latch metadata shadowed by the pipeline controller.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    regbits_t writeReg;
    logic     regWEN;
    logic     dmemREN;
    logic     dmemWEN;
    logic     halt;
  } pipe_meta_t;

  // Latch-control bundle, one bit per pipeline enable/flush.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE = '0;

  function automatic logic is_mem_op(input pipe_meta_t m);
    return m.dmemREN | m.dmemWEN;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline controller and its environment
// (hazard unit, memories, decode). Counter outputs exist only with PIPE_PERF_EN.
interface pipe_ctrl_if #(
  parameter int REG_W = 5
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
);

  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] id_wsel;
  logic             id_regWEN;
  logic             id_dmemREN;
  logic             id_dmemWEN;
  logic             id_halt;
  logic             hazard;
  logic             branch;
  logic             jump;

  logic [REG_W-1:0] ex_writeReg;
  logic             ex_regWEN;
  logic             ex_dmemREN;
  logic [REG_W-1:0] mem_writeReg;
  logic             mem_regWEN;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  // Environment side: drives hits, decode info and hazard results.
  modport master (
`ifdef PIPE_PERF_EN
    input  stall_cnt, flush_cnt,
`endif
    output ihit, dhit, id_wsel, id_regWEN, id_dmemREN, id_dmemWEN, id_halt,
    output hazard, branch, jump,
    input  ex_writeReg, ex_regWEN, ex_dmemREN, mem_writeReg, mem_regWEN,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halt
  );

  // Controller side.
  modport slave (
`ifdef PIPE_PERF_EN
    output stall_cnt, flush_cnt,
`endif
    input  ihit, dhit, id_wsel, id_regWEN, id_dmemREN, id_dmemWEN, id_halt,
    input  hazard, branch, jump,
    output ex_writeReg, ex_regWEN, ex_dmemREN, mem_writeReg, mem_regWEN,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halt
  );

endinterface

// File: rtl/pipe_meta_reg.sv
// One pipeline-latch shadow of instruction metadata; flush clears the slot
// and takes priority over enable.
module pipe_meta_reg
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       en,
  input  logic       flush,
  input  pipe_meta_t d,
  output pipe_meta_t q
);

  // NOTE: sequential state uses non-blocking assignment so every latch in the
  // chain samples its upstream value from before the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: shadows ID/EX, EX/MEM, MEM/WB metadata, sequences data
// waits and halt, and drives latch enables/flushes. PIPE_PERF_EN adds counters.
module pipe_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic        CLK,
  input logic        nRST,
  pipe_ctrl_if.slave bus
);

  pipe_state_t state;
  logic        halt_q;
  pipe_meta_t  id_meta;
  pipe_meta_t  idex_q;
  pipe_meta_t  exmem_q;
  pipe_meta_t  memwb_q;
  pipe_ctl_t   ctl;
  logic        mem_stall;

  assign id_meta = '{
    writeReg: regbits_t'(bus.id_wsel),
    regWEN:   bus.id_regWEN,
    dmemREN:  bus.id_dmemREN,
    dmemWEN:  bus.id_dmemWEN,
    halt:     bus.id_halt
  };

  // A memory op sitting in EX/MEM (or an ongoing wait) freezes the pipe until dhit.
  assign mem_stall = ((state == DWAIT) || is_mem_op(exmem_q)) && !bus.dhit;

  // NOTE: ctl gets a full default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctl = CTL_IDLE;
    if (nRST && (state != HALTED) && !mem_stall) begin
      ctl.idex_en  = 1'b1;
      ctl.exmem_en = 1'b1;
      ctl.memwb_en = 1'b1;
      if (bus.hazard || !bus.ihit) begin
        // Hold PC and IF/ID, drop a bubble into ID/EX; hazard beats branch.
        ctl.idex_flush = 1'b1;
      end else begin
        ctl.pc_en      = 1'b1;
        ctl.ifid_en    = 1'b1;
        ctl.ifid_flush = bus.branch | bus.jump;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memwb_q.halt) begin
            state  <= HALTED;
            halt_q <= 1'b1;
          end else if (mem_stall) begin
            state <= DWAIT;
          end
        end
        DWAIT: begin
          if (memwb_q.halt) begin
            state  <= HALTED;
            halt_q <= 1'b1;
          end else if (bus.dhit) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halt_q <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halt_q <= 1'b0;
        end
      endcase
    end
  end

  pipe_meta_reg u_idex (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ctl.idex_en),
    .flush (ctl.idex_flush),
    .d     (id_meta),
    .q     (idex_q)
  );

  pipe_meta_reg u_exmem (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ctl.exmem_en),
    .flush (ctl.exmem_flush),
    .d     (idex_q),
    .q     (exmem_q)
  );

  pipe_meta_reg u_memwb (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ctl.memwb_en),
    .flush (1'b0),
    .d     (exmem_q),
    .q     (memwb_q)
  );

  // Only the halt marker is consumed at write-back; the rest rides along.
  logic unused_wb;
  assign unused_wb = ^{memwb_q.writeReg, memwb_q.regWEN, memwb_q.dmemREN, memwb_q.dmemWEN};

  assign bus.ex_writeReg  = REG_W'(idex_q.writeReg);
  assign bus.ex_regWEN    = idex_q.regWEN;
  assign bus.ex_dmemREN   = idex_q.dmemREN;
  assign bus.mem_writeReg = REG_W'(exmem_q.writeReg);
  assign bus.mem_regWEN   = exmem_q.regWEN;

  assign bus.pc_en       = ctl.pc_en;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.idex_en     = ctl.idex_en;
  assign bus.exmem_en    = ctl.exmem_en;
  assign bus.memwb_en    = ctl.memwb_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_flush  = ctl.idex_flush;
  assign bus.exmem_flush = ctl.exmem_flush;
  assign bus.halt        = halt_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state != HALTED) begin
      if (!ctl.pc_en && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((ctl.ifid_flush || ctl.idex_flush || ctl.exmem_flush) && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: rule table, hand sequences for stalls,
// load-use, data wait and halt, then random traffic against a stage model.
module tb_pipe_ctrl;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipe_ctrl_if #(.REG_W(5)) bus ();

  pipe_ctrl #(.REG_W(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0] wr;
    logic       rwen;
    logic       ren;
    logic       wen;
    logic       hlt;
  } meta_t;

  typedef struct packed {
    logic  ihit;
    logic  dhit;
    logic  hazard;
    logic  branch;
    logic  jump;
    meta_t id;
  } stim_t;

  // Control vector bit order: pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl
  typedef struct packed {
    stim_t      s;
    logic [7:0] exp;
  } vec_t;

  localparam meta_t NOP = '0;

  function automatic meta_t md(input logic [4:0] wr, input logic rwen, input logic ren,
                               input logic wen, input logic hlt);
    return '{wr, rwen, ren, wen, hlt};
  endfunction

  function automatic stim_t st(input logic ih, input logic dh, input logic hz,
                               input logic br, input logic jp, input meta_t id);
    return '{ih, dh, hz, br, jp, id};
  endfunction

  // ---------------- reference model: three stage slots + wait/halt flags
  meta_t       m_ex, m_mem, m_wb;
  bit          m_wait, m_halted;
  logic [31:0] m_stall, m_flush;
  logic [7:0]  last_ctl;

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_wait = 0; m_halted = 0;
    m_stall = '0; m_flush = '0;
  endfunction

  function automatic logic [7:0] model_ctl(input stim_t s);
    if (m_halted) return 8'b0000_0000;
    if ((m_wait || m_mem.ren || m_mem.wen) && !s.dhit) return 8'b0000_0000;
    if (s.hazard || !s.ihit) return 8'b0011_1010;
    if (s.branch || s.jump) return 8'b1111_1100;
    return 8'b1111_1000;
  endfunction

  function automatic void model_step(input stim_t s, input logic [7:0] c);
    meta_t nex, nmem, nwb;
    bit    memop;
    memop = m_mem.ren || m_mem.wen;
    nex   = c[1] ? NOP : (c[5] ? s.id : m_ex);
    nmem  = c[0] ? NOP : (c[4] ? m_ex : m_mem);
    nwb   = c[3] ? m_mem : m_wb;
    if (!m_halted) begin
      if (!c[7]) m_stall++;
      if (|c[2:0]) m_flush++;
    end
    m_wait   = !m_halted && !m_wb.hlt && (m_wait || memop) && !s.dhit;
    m_halted = m_halted || m_wb.hlt;
    m_ex = nex; m_mem = nmem; m_wb = nwb;
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  endfunction

  function automatic logic [21:0] dut_obs();
    return {dut_ctl(), bus.ex_writeReg, bus.ex_regWEN, bus.ex_dmemREN,
            bus.mem_writeReg, bus.mem_regWEN, bus.halt};
  endfunction

  task automatic drive(input stim_t s);
    bus.ihit       = s.ihit;
    bus.dhit       = s.dhit;
    bus.hazard     = s.hazard;
    bus.branch     = s.branch;
    bus.jump       = s.jump;
    bus.id_wsel    = s.id.wr;
    bus.id_regWEN  = s.id.rwen;
    bus.id_dmemREN = s.id.ren;
    bus.id_dmemWEN = s.id.wen;
    bus.id_halt    = s.id.hlt;
  endtask

  // One clock: drive after the edge, compare at negedge, advance model after the edge.
  task automatic cycle(input stim_t s, input string tag);
    logic [7:0]  c;
    logic [21:0] exp_o, mask;
    drive(s);
    @(negedge CLK);
    c     = model_ctl(s);
    exp_o = {c, m_ex.wr, m_ex.rwen, m_ex.ren, m_mem.wr, m_mem.rwen, m_halted};
    // idex_en is a don't-care whenever ID/EX is being flushed
    mask  = c[1] ? ~(22'd1 << 19) : '1;
    last_ctl = dut_ctl();
    check(tag, 64'(dut_obs() & mask), 64'(exp_o & mask));
`ifdef PIPE_PERF_EN
    check({tag, " perf"}, {bus.stall_cnt, bus.flush_cnt}, {m_stall, m_flush});
`endif
    @(posedge CLK);
    #1;
    model_step(s, c);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive(st(1, 1, 0, 0, 0, NOP));
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
  endtask

  function automatic stim_t rand_stim();
    meta_t id;
    id = md(5'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 6) == 0, 1'b0);
    return st(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
              ($urandom % 5) == 0, ($urandom % 8) == 0, id);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  vec_t vt[9];

  initial begin
    vt[0] = '{st(1, 1, 0, 0, 0, NOP), 8'b1111_1000};
    vt[1] = '{st(1, 1, 1, 0, 0, NOP), 8'b0011_1010};
    vt[2] = '{st(0, 1, 0, 0, 0, NOP), 8'b0011_1010};
    vt[3] = '{st(1, 1, 0, 1, 0, NOP), 8'b1111_1100};
    vt[4] = '{st(1, 1, 0, 0, 1, NOP), 8'b1111_1100};
    vt[5] = '{st(0, 1, 0, 1, 0, NOP), 8'b0011_1010};
    vt[6] = '{st(1, 1, 1, 1, 0, NOP), 8'b0011_1010};
    vt[7] = '{st(1, 0, 0, 0, 0, NOP), 8'b1111_1000};
    vt[8] = '{st(0, 0, 1, 0, 1, NOP), 8'b0011_1010};

    // Reset held with random inputs: everything quiet.
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(rand_stim());
      @(negedge CLK);
      check("reset quiet", 64'(dut_obs()), 64'd0);
    end
    @(posedge CLK);
    #1;
    drive(st(1, 1, 0, 0, 0, NOP));
    nRST = 1'b1;
    @(negedge CLK);
    check("reset release", 64'(dut_ctl()), 64'(8'b1111_1000));

    // Rule table from an empty RUN pipeline.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] m;
      drive(vt[i].s);
      @(negedge CLK);
      m = vt[i].exp[1] ? 8'hDF : 8'hFF;
      check($sformatf("table[%0d]", i), 64'(dut_ctl() & m), 64'(vt[i].exp & m));
      @(posedge CLK);
      #1;
    end

    // Load-use: load r5, then hazard on the consumer.
    do_reset();
    cycle(st(1, 1, 0, 0, 0, md(5, 1, 1, 0, 0)), "lu load");
    cycle(st(1, 1, 1, 0, 0, md(7, 1, 0, 0, 0)), "lu hazard");
    check("lu pc_en", 64'(last_ctl[7]), 64'd0);
    check("lu ifid_en", 64'(last_ctl[6]), 64'd0);
    check("lu idex_flush", 64'(last_ctl[1]), 64'd1);
    check("lu ex_regWEN", 64'(bus.ex_regWEN), 64'd0);
    check("lu mem_writeReg", 64'(bus.mem_writeReg), 64'd5);
    cycle(st(1, 1, 0, 0, 0, md(7, 1, 0, 0, 0)), "lu resume");
    check("lu ex_writeReg", 64'(bus.ex_writeReg), 64'd7);

    // Data wait: load in EX/MEM with three dhit=0 cycles.
    do_reset();
    cycle(st(1, 1, 0, 0, 0, md(3, 1, 1, 0, 0)), "dw load");
    cycle(st(1, 1, 0, 0, 0, md(9, 1, 0, 0, 0)), "dw next");
    for (int k = 0; k < 3; k++) begin
      cycle(st(1, 0, 0, 0, 0, md(10, 1, 0, 0, 0)), "dw wait");
      check("dw stalled", 64'(last_ctl), 64'd0);
    end
    cycle(st(1, 1, 0, 0, 0, md(10, 1, 0, 0, 0)), "dw done");
    check("dw release", 64'(last_ctl), 64'(8'b1111_1000));
    check("dw mem_writeReg", 64'(bus.mem_writeReg), 64'd9);
    check("dw ex_writeReg", 64'(bus.ex_writeReg), 64'd10);

    // Random traffic against the model, then an asynchronous reset mid-cycle.
    do_reset();
    for (int k = 0; k < 400; k++) cycle(rand_stim(), "rand");
    #3;
    nRST = 1'b0;
    #1;
    check("async reset", 64'(dut_obs()), 64'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) cycle(rand_stim(), "rand post-reset");

    // Halt: appears exactly four cycles after id_halt, then sticks.
    do_reset();
    cycle(st(1, 1, 0, 0, 0, md(0, 0, 0, 0, 1)), "halt issue");
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("halt +%0d", k), 64'(bus.halt), 64'(k == 4));
      if (k < 4) cycle(st(1, 1, 0, 0, 0, NOP), "halt drain");
    end
    for (int k = 0; k < 6; k++) begin
      cycle(st(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, NOP), "halted");
    end
    check("halt sticky", 64'(bus.halt), 64'd1);
    check("halted ctl", 64'(last_ctl), 64'd0);

`ifdef PIPE_PERF_EN
    do_reset();
    cycle(st(1, 1, 1, 0, 0, NOP), "perf hazard");
    cycle(st(1, 1, 1, 0, 0, NOP), "perf hazard");
    cycle(st(1, 1, 0, 1, 0, NOP), "perf branch");
    cycle(st(1, 1, 0, 0, 0, NOP), "perf idle");
    check("stall_cnt", 64'(bus.stall_cnt), 64'd2);
    check("flush_cnt", 64'(bus.flush_cnt), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
